// File: rtl/rv4028_bus_bridge.sv
// Bridge from the 32-bit FemtoRV32 memory port to the narrow RV4028 external bus.
// Splits accesses into BUS_W beats, serves on-chip ROM reads and handles busrq/busack release.
module rv4028_bus_bridge #(
  parameter int         BUS_W    = 16,
  parameter logic [7:0] ROM_BASE = 8'h08,
  parameter int         ROM_AW   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  input  logic [3:0]         cpu_mask,
  input  logic               cpu_half,
  input  logic               cpu_rstrb,
  input  logic               cpu_wstrb,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_rbusy,
  output logic               cpu_wbusy,
  output logic [31:0]        bus_addr,
  output logic               bus_rd_n,
  output logic               bus_wr_n,
  output logic [BUS_W/8-1:0] bus_msk_n,
  output logic               bus_mreq_n,
  output logic               bus_iorq_n,
  input  logic               bus_wait_n,
  input  logic               bus_rq_n,
  output logic               bus_ack_n,
  input  logic [BUS_W-1:0]   bus_din,
  output logic [BUS_W-1:0]   bus_dout,
  output logic               bus_oe,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [BUS_W-1:0]   rom_data
);
  localparam int BB = BUS_W / 8;
  localparam int NB = 32 / BUS_W;
  localparam int LB = $clog2(BB);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef logic [NB-1:0][BB-1:0] lanes_t;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, REL} state_t;

  state_t                      state;
  logic [31:2]                 acc_word;
  logic [NB-1:0][BUS_W-1:0]    acc_wdata;
  lanes_t                      acc_lanes;
  logic                        acc_wr, acc_rom, pend, wait_r;
  logic [BW-1:0]               beat;

  logic                        req, st_wr, st_rom, iss_sel, iss_wr, iss_rom, iss_ok, done;
  logic [31:2]                 st_word, iss_word;
  lanes_t                      req_lanes, st_lanes, iss_lanes;
  logic [BW-1:0]               iss_idx;
  logic [1:0]                  iss_off;
  logic [BUS_W-1:0]            rd_src;
  int                          iss_from;
  logic                        unused;

  // Lowest beat index at or above 'from' whose lanes are non-zero.
  function automatic logic [BW:0] find_beat(input lanes_t ln, input int from);
    logic [BW:0] r;
    r = '0;
    for (int b = NB - 1; b >= 0; b--)
      if (b >= from && ln[b] != '0) r = {1'b1, BW'(b)};
    return r;
  endfunction

  assign unused   = cpu_addr[0];
  assign rom_addr = bus_addr[ROM_AW+LB-1:LB];

  always_comb begin
    req       = cpu_rstrb | cpu_wstrb;
    req_lanes = cpu_wstrb ? cpu_mask : (cpu_half ? (cpu_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111);
    // A pending access (captured during release) takes precedence over live inputs.
    st_word   = pend ? acc_word  : cpu_addr[31:2];
    st_lanes  = pend ? acc_lanes : req_lanes;
    st_wr     = pend ? acc_wr    : cpu_wstrb;
    st_rom    = !st_wr && st_word[31:24] == ROM_BASE;
    iss_sel   = (state == IDLE);
    iss_word  = iss_sel ? st_word  : acc_word;
    iss_lanes = iss_sel ? st_lanes : acc_lanes;
    iss_wr    = iss_sel ? st_wr    : acc_wr;
    iss_rom   = iss_sel ? st_rom   : acc_rom;
    iss_from  = iss_sel ? 0 : int'(beat) + 1;
    {iss_ok, iss_idx} = find_beat(iss_lanes, iss_from);
    iss_off   = 2'(int'(iss_idx) * BB);
    done      = acc_rom | wait_r;
    rd_src    = acc_rom ? rom_data : bus_din;
    cpu_rbusy = cpu_rstrb | ((state == ADDR || state == DATA) && !acc_wr) | (pend && !acc_wr);
    cpu_wbusy = cpu_wstrb | ((state == ADDR || state == DATA) &&  acc_wr) | (pend &&  acc_wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      wait_r     <= 1'b1;
      bus_ack_n  <= 1'b1;
      bus_rd_n   <= 1'b1;
      bus_wr_n   <= 1'b1;
      bus_mreq_n <= 1'b1;
      bus_iorq_n <= 1'b1;
      bus_oe     <= 1'b0;
      cpu_rdata  <= '0;
      bus_addr   <= '0;
      bus_msk_n  <= '1;
      bus_dout   <= '0;
      acc_word   <= '0;
      acc_wdata  <= '0;
      acc_lanes  <= '0;
      acc_wr     <= 1'b0;
      acc_rom    <= 1'b0;
      beat       <= '0;
    end else begin
      wait_r <= bus_wait_n;
      case (state)
        IDLE: begin
          if (pend || req) begin
            pend      <= 1'b0;
            acc_word  <= st_word;
            acc_lanes <= st_lanes;
            acc_wr    <= st_wr;
            acc_rom   <= st_rom;
            if (!pend) acc_wdata <= cpu_wdata;
            if (!st_wr) cpu_rdata <= '0;
          end else if (!bus_rq_n) begin
            state     <= REL;
            bus_ack_n <= 1'b0;
          end
        end
        ADDR: begin
          state    <= DATA;
          bus_oe   <= acc_wr;
          bus_dout <= acc_wdata[beat];
        end
        DATA: begin
          if (done) begin
            for (int b = 0; b < NB; b++)
              for (int i = 0; i < BB; i++)
                if (!acc_wr && b == int'(beat) && acc_lanes[b][i])
                  cpu_rdata[(b*BB+i)*8 +: 8] <= rd_src[i*8 +: 8];
            if (!iss_ok) begin
              state      <= IDLE;
              bus_rd_n   <= 1'b1;
              bus_wr_n   <= 1'b1;
              bus_mreq_n <= 1'b1;
              bus_iorq_n <= 1'b1;
              bus_oe     <= 1'b0;
            end
          end
        end
        REL: begin
          if (req) begin
            pend      <= 1'b1;
            acc_word  <= cpu_addr[31:2];
            acc_wdata <= cpu_wdata;
            acc_lanes <= req_lanes;
            acc_wr    <= cpu_wstrb;
          end
          if (bus_rq_n) begin
            state     <= IDLE;
            bus_ack_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Beat issue, shared by access start and beat-to-beat advance.
      if (iss_ok && ((state == IDLE && (pend || req)) || (state == DATA && done))) begin
        state      <= ADDR;
        beat       <= iss_idx;
        bus_addr   <= {iss_word, iss_off};
        bus_msk_n  <= ~iss_lanes[iss_idx];
        bus_mreq_n <= 1'b0;
        bus_iorq_n <= ~iss_word[31];
        bus_rd_n   <= iss_wr | iss_rom;
        bus_wr_n   <= ~iss_wr;
        bus_oe     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv4028_bus_bridge.sv
// Bench for rv4028_bus_bridge: 16-bit and 8-bit instances, vector table plus hand-written corner sequences.
module tb_rv4028_bus_bridge;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_mask = '0;
  logic        cpu_half = 1'b0;
  logic        rstrb16 = 1'b0, wstrb16 = 1'b0, rstrb8 = 1'b0, wstrb8 = 1'b0;
  logic        bus_wait_n = 1'b1, bus_rq_n = 1'b1;

  logic [31:0] rdata16, bus_addr16, rdata8, bus_addr8;
  logic        rbusy16, wbusy16, rd16, wr16, mreq16, iorq16, ack16, oe16;
  logic        rbusy8, wbusy8, rd8, wr8, mreq8, iorq8, ack8, oe8;
  logic [1:0]  msk16;
  logic [0:0]  msk8;
  logic [15:0] dout16, din16, rom16_q = '0;
  logic [7:0]  dout8, din8, rom8_q = '0;
  logic [11:0] rom_addr16, rom_addr8;

  int n_checks = 0, n_fail = 0;

  function automatic logic [15:0] mem16(input logic [31:0] a);
    if (a == 32'h1000) return 16'h1234;
    if (a == 32'h1002) return 16'h5678;
    return a[15:0] ^ 16'h3C5A;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic h);
    logic [31:0] a0;
    a0 = {a[31:2], 2'b00};
    if (!h) return {mem16(a0 | 32'h2), mem16(a0)};
    if (a[1]) return {mem16(a0 | 32'h2), 16'h0};
    return {16'h0, mem16(a0)};
  endfunction

  assign din16 = mem16(bus_addr16);
  assign din8  = bus_addr8[7:0] ^ 8'h5A;
  always @(posedge clk) begin
    rom16_q <= {4'hC, rom_addr16};
    rom8_q  <= rom_addr8[7:0];
  end

  rv4028_bus_bridge #(.BUS_W(16)) u16 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mask(cpu_mask),
    .cpu_half(cpu_half), .cpu_rstrb(rstrb16), .cpu_wstrb(wstrb16), .cpu_rdata(rdata16),
    .cpu_rbusy(rbusy16), .cpu_wbusy(wbusy16), .bus_addr(bus_addr16), .bus_rd_n(rd16),
    .bus_wr_n(wr16), .bus_msk_n(msk16), .bus_mreq_n(mreq16), .bus_iorq_n(iorq16),
    .bus_wait_n(bus_wait_n), .bus_rq_n(bus_rq_n), .bus_ack_n(ack16), .bus_din(din16),
    .bus_dout(dout16), .bus_oe(oe16), .rom_addr(rom_addr16), .rom_data(rom16_q));

  rv4028_bus_bridge #(.BUS_W(8)) u8 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mask(cpu_mask),
    .cpu_half(cpu_half), .cpu_rstrb(rstrb8), .cpu_wstrb(wstrb8), .cpu_rdata(rdata8),
    .cpu_rbusy(rbusy8), .cpu_wbusy(wbusy8), .bus_addr(bus_addr8), .bus_rd_n(rd8),
    .bus_wr_n(wr8), .bus_msk_n(msk8), .bus_mreq_n(mreq8), .bus_iorq_n(iorq8),
    .bus_wait_n(bus_wait_n), .bus_rq_n(bus_rq_n), .bus_ack_n(ack8), .bus_din(din8),
    .bus_dout(dout8), .bus_oe(oe8), .rom_addr(rom_addr8), .rom_data(rom8_q));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor for the 16-bit instance.
  int          mreq_cyc = 0, rd_low = 0;
  logic [31:0] wr_word = '0;
  logic [31:0] beatq[$];
  logic [11:0] romq[$];
  logic        prev_mreq = 1'b1;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!mreq16 && (prev_mreq || bus_addr16 != prev_addr)) begin
        beatq.push_back(bus_addr16);
        romq.push_back(rom_addr16);
      end
      if (!mreq16) begin
        mreq_cyc++;
        chk("iorq_n", {31'b0, iorq16}, {31'b0, ~bus_addr16[31]});
      end
      if (!rd16) rd_low++;
      if (oe16)
        for (int i = 0; i < 2; i++)
          if (!msk16[i]) wr_word[((bus_addr16[1] ? 2 : 0) + i)*8 +: 8] = dout16[i*8 +: 8];
    end
    prev_mreq = mreq16;
    prev_addr = bus_addr16;
  end

  // One access on the 16-bit instance; wait_n held low for the first nwait cycles after the strobe.
  task automatic do16(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                      input logic h, input int nwait, output int busy_cyc, output logic [31:0] rd);
    bit fin;
    mreq_cyc = 0; rd_low = 0; wr_word = '0; beatq.delete(); romq.delete();
    cpu_addr = a; cpu_wdata = wd; cpu_mask = m; cpu_half = h;
    if (wr) wstrb16 = 1'b1; else rstrb16 = 1'b1;
    busy_cyc = 0; fin = 0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      if (rbusy16 | wbusy16) busy_cyc++; else fin = 1;
      if (!fin) begin
        @(posedge clk); #1;
        rstrb16 = 1'b0; wstrb16 = 1'b0;
        bus_wait_n = (i < nwait) ? 1'b0 : 1'b1;
      end
    end
    rd = rdata16;
    if (!fin) chk("busy_timeout", 32'd1, 32'd0);
    bus_wait_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        half;
    int          beats;
  } vec_t;
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [31:0] wword;
    int          busy;
    int          mreq;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  initial begin
    exp_t e, got_e;
    int busy;
    logic [31:0] rd;
    bit fin;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0, 2};
    vecs[1] = '{1'b0, 32'h0000_0102, 32'h0, 4'b0000, 1'b1, 1};
    vecs[2] = '{1'b0, 32'h0000_0204, 32'h0, 4'b0000, 1'b1, 1};
    vecs[3] = '{1'b0, 32'h8000_0010, 32'h0, 4'b0000, 1'b0, 2};
    vecs[4] = '{1'b1, 32'h0000_0300, 32'hDEADBEEF, 4'b1111, 1'b0, 2};
    vecs[5] = '{1'b1, 32'h0000_0304, 32'h01234567, 4'b0001, 1'b0, 1};
    vecs[6] = '{1'b1, 32'h0000_0308, 32'h89ABCDEF, 4'b1000, 1'b0, 1};
    vecs[7] = '{1'b1, 32'h0000_030C, 32'h13572468, 4'b0110, 1'b0, 2};
    vecs[8] = '{1'b1, 32'h0000_0310, 32'hFFFFFFFF, 4'b0000, 1'b0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_n",   {31'b0, rd16},   32'd1);
    chk("rst_wr_n",   {31'b0, wr16},   32'd1);
    chk("rst_mreq_n", {31'b0, mreq16}, 32'd1);
    chk("rst_iorq_n", {31'b0, iorq16}, 32'd1);
    chk("rst_ack_n",  {31'b0, ack16},  32'd1);
    chk("rst_oe",     {31'b0, oe16},   32'd0);
    chk("rst_rdata",  rdata16,         32'd0);
    chk("rst_busy",   {30'b0, rbusy16, wbusy16}, 32'd0);
    @(posedge clk); #1;

    // 8-bit single-lane write
    cpu_addr = 32'h200; cpu_wdata = 32'hAABBCCDD; cpu_mask = 4'b0100; wstrb8 = 1'b1;
    @(negedge clk); chk("w8_busy0", {31'b0, wbusy8}, 32'd1);
    @(posedge clk); #1 wstrb8 = 1'b0;
    @(negedge clk);
    chk("w8_addr", bus_addr8, 32'h202);
    chk("w8_wr_n_a", {31'b0, wr8}, 32'd0);
    chk("w8_msk_n", {31'b0, msk8}, 32'd0);
    chk("w8_oe_a", {31'b0, oe8}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w8_wr_n_d", {31'b0, wr8}, 32'd0);
    chk("w8_oe_d", {31'b0, oe8}, 32'd1);
    chk("w8_dout", {24'b0, dout8}, 32'hBB);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w8_wr_n_end", {31'b0, wr8}, 32'd1);
    chk("w8_busy_end", {31'b0, wbusy8}, 32'd0);
    @(posedge clk); #1;

    // Word read, two beats
    do16(1'b0, 32'h1000, 32'h0, 4'b0, 1'b0, 0, busy, rd);
    chk("rd_busy", busy, 32'd5);
    chk("rd_data", rd, 32'h5678_1234);
    chk("rd_nbeats", beatq.size(), 32'd2);
    if (beatq.size() == 2) begin
      chk("rd_beat0", beatq[0], 32'h1000);
      chk("rd_beat1", beatq[1], 32'h1002);
    end

    // Vector table through the scoreboard
    for (int v = 0; v < 9; v++) begin
      e.wr    = vecs[v].wr;
      e.busy  = 1 + 2 * vecs[v].beats;
      e.mreq  = 2 * vecs[v].beats;
      e.rdata = vecs[v].wr ? 32'h0 : exp_read(vecs[v].addr, vecs[v].half);
      e.wword = vecs[v].wdata & {{8{vecs[v].mask[3]}}, {8{vecs[v].mask[2]}},
                                 {8{vecs[v].mask[1]}}, {8{vecs[v].mask[0]}}};
      sb.push_back(e);
      do16(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].mask, vecs[v].half, 0, busy, rd);
      got_e = sb.pop_front();
      chk($sformatf("v%0d_busy", v), busy, got_e.busy);
      chk($sformatf("v%0d_mreq", v), mreq_cyc, got_e.mreq);
      if (got_e.wr) chk($sformatf("v%0d_wword", v), wr_word, got_e.wword);
      else          chk($sformatf("v%0d_rdata", v), rd, got_e.rdata);
    end

    // Half read, upper half, three wait cycles
    do16(1'b0, 32'h0000_0402, 32'h0, 4'b0, 1'b1, 3, busy, rd);
    chk("wt_busy", busy, 32'd6);
    chk("wt_mreq", mreq_cyc, 32'd5);
    chk("wt_nbeats", beatq.size(), 32'd1);
    if (beatq.size() == 1) chk("wt_beat", beatq[0], 32'h402);
    chk("wt_rdata", rd, {mem16(32'h402), 16'h0});

    // ROM read, wait_n low throughout
    do16(1'b0, 32'h0800_0010, 32'h0, 4'b0, 1'b0, 50, busy, rd);
    chk("rom_busy", busy, 32'd5);
    chk("rom_rd_low", rd_low, 32'd0);
    chk("rom_nbeats", romq.size(), 32'd2);
    if (romq.size() == 2) begin
      chk("rom_addr0", {20'b0, romq[0]}, 32'd8);
      chk("rom_addr1", {20'b0, romq[1]}, 32'd9);
    end
    chk("rom_rdata", rd, 32'hC009_C008);

    // Bus release with a read captured as pending
    bus_rq_n = 1'b0;
    @(negedge clk); chk("rel_ack_c0", {31'b0, ack16}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("rel_ack_c1", {31'b0, ack16}, 32'd0);
    @(posedge clk); #1 cpu_addr = 32'h600; cpu_half = 1'b0; rstrb16 = 1'b1;
    @(negedge clk);
    chk("rel_busy_c2", {31'b0, rbusy16}, 32'd1);
    chk("rel_mreq_c2", {31'b0, mreq16}, 32'd1);
    @(posedge clk); #1 rstrb16 = 1'b0;
    @(negedge clk);
    chk("rel_busy_c3", {31'b0, rbusy16}, 32'd1);
    chk("rel_ack_c3", {31'b0, ack16}, 32'd0);
    chk("rel_mreq_c3", {31'b0, mreq16}, 32'd1);
    @(posedge clk); #1 bus_rq_n = 1'b1;
    @(negedge clk); chk("rel_ack_c4", {31'b0, ack16}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_ack_c5", {31'b0, ack16}, 32'd1);
    chk("rel_busy_c5", {31'b0, rbusy16}, 32'd1);
    chk("rel_mreq_c5", {31'b0, mreq16}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_mreq_c6", {31'b0, mreq16}, 32'd0);
    chk("rel_rd_c6", {31'b0, rd16}, 32'd0);
    chk("rel_addr_c6", bus_addr16, 32'h600);
    fin = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      if (!rbusy16) fin = 1;
    end
    if (!fin) chk("rel_timeout", 32'd1, 32'd0);
    chk("rel_rdata", rdata16, exp_read(32'h600, 1'b0));
    @(posedge clk); #1;

    // Reset during DATA of beat 0
    cpu_addr = 32'h700; rstrb16 = 1'b1;
    @(posedge clk); #1 rstrb16 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ra_rd_n", {31'b0, rd16}, 32'd1);
    chk("ra_mreq_n", {31'b0, mreq16}, 32'd1);
    chk("ra_busy", {31'b0, rbusy16}, 32'd0);
    chk("ra_ack_n", {31'b0, ack16}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    do16(1'b0, 32'h800, 32'h0, 4'b0, 1'b0, 0, busy, rd);
    chk("ra_new_busy", busy, 32'd5);
    chk("ra_new_rdata", rd, exp_read(32'h800, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
